cpu_memory: RTL
===============

CPU_MEMORY -- requirements
Module: cpu_memory

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit words in the array; the value SHALL be a power of two, minimum 4.
REQ-002 Parameter ADDR_BITS, default 8, word-index width; the value SHALL equal log2(DEPTH_WORDS).
REQ-003 Port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port instr_addr  input  32  byte address of the instruction fetch.
REQ-006 Port instr  output  32  fetched instruction word.
REQ-007 Port data_addr  input  32  byte address of the data access.
REQ-008 Port mem_read_data  output  32  load data returned to the CPU.
REQ-009 Port mem_write_data  input  32  store data from the CPU.
REQ-010 Port mem_read_en  input  1  data read request.
REQ-011 Port mem_write_en  input  1  data write request.
REQ-012 Port load_valid  input  1  preload word valid.
REQ-013 Port load_ready  output  1  preload word accepted this cycle when high with load_valid.
REQ-014 Port load_data  input  32  preload word.
REQ-015 Port load_last  input  1  marks the final preload word.
REQ-016 Port cpu_rst  output  1  reset to the CPU core; high until the array is ready.
REQ-017 Port fault  output  1  sticky illegal-access flag.
REQ-018 Port fault_addr  output  32  byte address of the first illegal access.

Function
REQ-019 The block SHALL implement a three-state FSM: CLEAR, LOAD and RUN.
REQ-020 In CLEAR, one word per cycle SHALL be written to zero at index ptr, starting from ptr=0; after index DEPTH_WORDS-1, ptr SHALL return to 0 and the state SHALL move to LOAD.
REQ-021 In LOAD, load_ready SHALL be 1; on load_valid&&load_ready, load_data SHALL be written at index ptr and ptr SHALL increment.
REQ-022 LOAD SHALL move to RUN on an accepted word with load_last=1, or on acceptance of the word at index DEPTH_WORDS-1, whichever occurs first.
REQ-023 load_ready SHALL be 0 in CLEAR and RUN; load_valid in those states SHALL be ignored, with no array write.
REQ-024 cpu_rst SHALL be 1 whenever state!=RUN, driven from the registered state with no combinational path from inputs.
REQ-025 instr SHALL equal mem[instr_addr[ADDR_BITS+1:2]] combinationally in RUN, and 32'h00000000 in CLEAR and LOAD.
REQ-026 mem_read_data SHALL equal mem[data_addr[ADDR_BITS+1:2]] combinationally when state==RUN and mem_read_en=1 and the access is legal; otherwise it SHALL be 0.
REQ-027 A data access (mem_read_en or mem_write_en high in RUN) SHALL be illegal if data_addr[1:0]!=0 or data_addr>=4*DEPTH_WORDS.
REQ-028 In RUN, a legal mem_write_en SHALL write mem_write_data at the rising edge; an illegal one SHALL leave the array unchanged.
REQ-029 If mem_read_en and mem_write_en are both high, the write SHALL occur at the edge and mem_read_data SHALL show the pre-write contents in that cycle.
REQ-030 Reads SHALL have zero-cycle latency (combinational); writes SHALL be visible on both read ports in the cycle after the edge.
REQ-031 On the first illegal access, fault SHALL go to 1 on the next edge and fault_addr SHALL capture data_addr; later illegal accesses SHALL NOT change fault_addr.
REQ-032 Instruction fetches SHALL never raise fault; instr_addr[1:0] and bits above ADDR_BITS+1 SHALL be ignored, so fetch addresses wrap.

Reset
REQ-033 When rst=1 at an edge, from any state (including mid-CLEAR and mid-LOAD), the block SHALL enter CLEAR with ptr=0, fault=0 and fault_addr=0.
REQ-034 In the cycle after reset, outputs SHALL be: cpu_rst=1, load_ready=0, instr=0, mem_read_data=0, fault=0, fault_addr=0.
REQ-035 rst SHALL take priority over any simultaneous load or write.

Verification
REQ-036 Release rst, count cycles -> load_ready rises exactly DEPTH_WORDS cycles later (256 at default), and instr=0 throughout.
REQ-037 Load 0x20080005, 0x20090007, 0x01095020 with load_last on the third word, load_valid gapped every other cycle -> cpu_rst falls the cycle after the third acceptance, and instr_addr=8 returns 0x01095020.
REQ-038 In RUN, write 0xDEADBEEF to data_addr=0x10 with mem_read_en also high -> mem_read_data shows the old value (0) that cycle and 0xDEADBEEF the next cycle.
REQ-039 In RUN, write to data_addr=0x13, then read data_addr=0x400 -> fault=1, fault_addr=0x13, array unchanged, and the read returns 0.
REQ-040 Stream DEPTH_WORDS words with load_last=0 -> RUN is entered after the last word, load_ready drops, and an extra load_valid does not alter word 0.
REQ-041 Assert rst midway through LOAD (ptr=50), then reload a single word 0x1 with load_last -> word 0=0x1 and word 49=0 after the new CLEAR.

Source files
------------

// File: rtl/cpu_memory.sv
// cpu_memory: unified instruction/data word array for a small CPU core.
// After reset the array is zeroed one word per cycle (CLEAR), then filled
// from a ready/valid preload stream (LOAD), then serves a combinational
// instruction fetch port and a combinational-read / edge-write data port (RUN).
// The CPU is held in reset until RUN. Illegal data accesses (misaligned or
// beyond the array) are suppressed and latched into a sticky fault record.
module cpu_memory #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_BITS   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr,
  input  logic [31:0] data_addr,
  output logic [31:0] mem_read_data,
  input  logic [31:0] mem_write_data,
  input  logic        mem_read_en,
  input  logic        mem_write_en,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        cpu_rst,
  output logic        fault,
  output logic [31:0] fault_addr
);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  // Single internal write port shared by clear, preload and CPU stores.
  typedef struct packed {
    logic                 en;
    logic [ADDR_BITS-1:0] idx;
    logic [31:0]          data;
  } wr_req_t;

  localparam logic [ADDR_BITS-1:0] LAST_IDX  = ADDR_BITS'(DEPTH_WORDS - 1);
  localparam logic [31:0]          MEM_BYTES = 32'(4 * DEPTH_WORDS);

  logic [DEPTH_WORDS-1:0][31:0] mem;

  state_t               state, state_n;
  logic [ADDR_BITS-1:0] ptr;
  wr_req_t              wr;

  logic [ADDR_BITS-1:0] iidx, didx;
  logic                 in_run, load_fire, bad_addr, data_access;
  logic                 illegal, legal_rd, legal_wr;

  // Fetch index ignores the byte offset and everything above the array,
  // so fetch addresses simply wrap.
  assign iidx = instr_addr[ADDR_BITS+1:2];
  assign didx = data_addr[ADDR_BITS+1:2];

  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr_addr[31:ADDR_BITS+2], instr_addr[1:0]};

  assign in_run      = (state == S_RUN);
  assign load_fire   = (state == S_LOAD) && load_valid;
  assign bad_addr    = (|data_addr[1:0]) || (data_addr >= MEM_BYTES);
  assign data_access = in_run && (mem_read_en || mem_write_en);
  assign illegal     = data_access && bad_addr;
  assign legal_rd    = in_run && mem_read_en  && !bad_addr;
  assign legal_wr    = in_run && mem_write_en && !bad_addr;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_CLEAR;
    else     state <= state_n;
  end

  // Next-state logic: CLEAR sweeps the whole array, LOAD ends on load_last
  // or when the final word has been accepted, RUN holds until reset.
  always_comb begin
    state_n = state;
    unique case (state)
      S_CLEAR: if (ptr == LAST_IDX) state_n = S_LOAD;
      S_LOAD:  if (load_fire && (load_last || ptr == LAST_IDX)) state_n = S_RUN;
      S_RUN:   state_n = S_RUN;
      default: state_n = S_CLEAR;
    endcase
  end

  // Outputs decode from registered state only; reads are combinational.
  always_comb begin
    load_ready    = (state == S_LOAD);
    cpu_rst       = !in_run;
    instr         = in_run   ? mem[iidx] : 32'h0;
    mem_read_data = legal_rd ? mem[didx] : 32'h0;
  end

  // Word pointer: advances every cycle in CLEAR (wrapping back to 0 for
  // LOAD because its width matches the array) and per accepted preload word.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else begin
      unique case (state)
        S_CLEAR: ptr <= ptr + 1'b1;
        S_LOAD:  if (load_fire) ptr <= ptr + 1'b1;
        default: ptr <= ptr;
      endcase
    end
  end

  // Select the source for the array write port by state.
  always_comb begin
    wr = '0;
    unique case (state)
      S_CLEAR: begin
        wr.en   = 1'b1;
        wr.idx  = ptr;
        wr.data = 32'h0;
      end
      S_LOAD: begin
        wr.en   = load_fire;
        wr.idx  = ptr;
        wr.data = load_data;
      end
      S_RUN: begin
        wr.en   = legal_wr;
        wr.idx  = didx;
        wr.data = mem_write_data;
      end
      default: wr = '0;
    endcase
  end

  // Array write; reset blocks any concurrent write. Contents are not reset
  // here because CLEAR zeroes them after every reset.
  always_ff @(posedge clk) begin
    if (!rst && wr.en) mem[wr.idx] <= wr.data;
  end

  // Sticky fault: only the first illegal access after reset records its address.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault      <= 1'b0;
      fault_addr <= 32'h0;
    end else if (illegal && !fault) begin
      fault      <= 1'b1;
      fault_addr <= data_addr;
    end
  end

endmodule
